fir_serial: RTL

FIR_SERIAL -- requirements
Module: fir_serial

---
 rtl/fir_pkg.sv | 26 ++
 rtl/fir_mac.sv | 48 ++++
 rtl/fir_serial.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared types and constants for the serial FIR filter (fir_serial / fir_mac).
//   DATA_W        : sample width (Q1.15 audio, codec bits [23:8])
//   COEF_W        : coefficient width (Q1.15)
//   sample_t      : signed sample type
//   coef_t        : signed coefficient type
//   state_t       : controller states IDLE / MAC
//   COEFS_DEFAULT : 16-tap 1/16 moving average (0x0800 = 1/16 in Q1.15)
// -----------------------------------------------------------------------------
package fir_pkg;

   localparam int DATA_W = 16;
   localparam int COEF_W = 16;

   typedef logic signed [DATA_W-1:0] sample_t;
   typedef logic signed [COEF_W-1:0] coef_t;

   typedef enum logic {
      IDLE = 1'b0,
      MAC  = 1'b1
   } state_t;

   localparam coef_t COEFS_DEFAULT [16] = '{default: 16'sh0800};

endpackage

// File: rtl/fir_mac.sv
// -----------------------------------------------------------------------------
// fir_mac
// Single multiply-accumulate datapath for the serial FIR.
// Ports:
//   ck     : clock, rising edge
//   rst    : synchronous active-high reset, clears the accumulator
//   coef   : signed Q1.15 coefficient for the current tap
//   sample : signed history sample for the current tap
//   clr    : clear accumulator (start of a new convolution)
//   en     : add coef*sample into the accumulator this edge
//   acc    : signed accumulator, ACC_W bits
// -----------------------------------------------------------------------------
module fir_mac
   import fir_pkg::*;
#(
   parameter int ACC_W = 36
) (
   input  logic                    ck,
   input  logic                    rst,
   input  coef_t                   coef,
   input  sample_t                 sample,
   input  logic                    clr,
   input  logic                    en,
   output logic signed [ACC_W-1:0] acc
);

   localparam int PROD_W = DATA_W + COEF_W;

   logic signed [PROD_W-1:0] w_prod_p0;
   logic signed [ACC_W-1:0]  r_acc_p1;

   // ---- stage p0: full-precision product (never overflows 32 bits) ----
   assign w_prod_p0 = PROD_W'(coef) * PROD_W'(sample);

   // ---- stage p1: accumulate; headroom of log2(NTAPS) bits covers the sum ----
   always_ff @(posedge ck) begin
      if (rst) begin
         r_acc_p1 <= '0;
      end else if (clr) begin
         r_acc_p1 <= '0;
      end else if (en) begin
         r_acc_p1 <= r_acc_p1 + ACC_W'(w_prod_p0);
      end
   end

   assign acc = r_acc_p1;

endmodule

// File: rtl/fir_serial.sv
// -----------------------------------------------------------------------------
// fir_serial
// Serial FIR filter: one multiply-accumulate per clock over a circular history
// buffer of NTAPS samples. A strobe in IDLE starts a convolution; the result
// appears NTAPS+1 edges later with a one-cycle output_ready pulse.
// Ports:
//   ck           : sole clock, rising edge
//   rst          : synchronous active-high reset (aborts any convolution)
//   in           : signed 16-bit input sample
//   input_ready  : one-cycle strobe, in is valid this cycle
//   out          : signed 16-bit filtered sample, held between results
//   output_ready : one-cycle strobe, out newly valid
//   busy         : high while a convolution is in progress
//   overrun      : sticky, a strobe arrived while busy (that sample is dropped)
// -----------------------------------------------------------------------------
module fir_serial
   import fir_pkg::*;
#(
   parameter int    NTAPS         = 16,
   parameter coef_t COEFS [NTAPS] = COEFS_DEFAULT
) (
   input  logic    ck,
   input  logic    rst,
   input  sample_t in,
   input  logic    input_ready,
   output sample_t out,
   output logic    output_ready,
   output logic    busy,
   output logic    overrun
);

   localparam int PTR_W = $clog2(NTAPS);
   localparam int K_W   = PTR_W + 1;          // k must reach NTAPS
   localparam int ACC_W = 32 + PTR_W;

   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(16384);
   localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-32768);

   // Round half up, drop 15 fraction bits, clamp to the 16-bit signed range.
   function automatic sample_t round_sat(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] r;
      r = (a + RND_HALF) >>> 15;
      if (r > SAT_MAX) begin
         return 16'sh7FFF;
      end else if (r < SAT_MIN) begin
         return 16'sh8000;
      end
      return sample_t'(r[DATA_W-1:0]);
   endfunction

   state_t               r_state;
   logic [K_W-1:0]       r_k;
   logic [PTR_W-1:0]     r_wr_ptr;
   sample_t              r_buf [NTAPS];
   sample_t              r_out;
   logic                 r_vld_p2;
   logic                 r_overrun;

   logic [PTR_W-1:0]        w_tap_idx;
   logic [PTR_W-1:0]        w_rd_ptr;
   logic                    w_last;
   logic                    w_mac_clr;
   logic                    w_mac_en;
   coef_t                   w_coef;
   sample_t                 w_sample;
   logic signed [ACC_W-1:0] w_acc;

   // ---- stage p0: tap selection; wr_ptr still points at the newest sample ----
   assign w_tap_idx = r_k[PTR_W-1:0];
   assign w_rd_ptr  = r_wr_ptr - w_tap_idx;   // power-of-two size wraps mod NTAPS
   assign w_coef    = COEFS[w_tap_idx];
   assign w_sample  = r_buf[w_rd_ptr];
   assign w_last    = (r_k == K_W'(NTAPS));   // all products are in the accumulator
   assign w_mac_clr = (r_state == IDLE) && input_ready;
   assign w_mac_en  = (r_state == MAC) && !w_last;

   fir_mac #(
      .ACC_W (ACC_W)
   ) u_mac (
      .ck     (ck),
      .rst    (rst),
      .coef   (w_coef),
      .sample (w_sample),
      .clr    (w_mac_clr),
      .en     (w_mac_en),
      .acc    (w_acc)
   );

   // ---- stage p2: control, history write, result register ----
   always_ff @(posedge ck) begin
      if (rst) begin
         r_state   <= IDLE;
         r_k       <= '0;
         r_wr_ptr  <= '0;
         r_out     <= '0;
         r_vld_p2  <= 1'b0;
         r_overrun <= 1'b0;
         for (int i = 0; i < NTAPS; i++) begin
            r_buf[i] <= '0;
         end
      end else begin
         r_vld_p2 <= 1'b0;
         case (r_state)
            IDLE: begin
               if (input_ready) begin
                  r_buf[r_wr_ptr] <= in;
                  r_k             <= '0;
                  r_state         <= MAC;
               end
            end
            MAC: begin
               // Strobes while busy are dropped; only the sticky flag records them.
               if (input_ready) begin
                  r_overrun <= 1'b1;
               end
               if (w_last) begin
                  r_out    <= round_sat(w_acc);
                  r_vld_p2 <= 1'b1;
                  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                  r_k      <= '0;
                  r_state  <= IDLE;
               end else begin
                  r_k <= r_k + K_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign out          = r_out;
   assign output_ready = r_vld_p2;
   assign busy         = (r_state == MAC);
   assign overrun      = r_overrun;

endmodule
